// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared types, default sizes and pointer helper for the FIR sequencer.
//   seq_state_t      : sequencer FSM state encoding
//   NUM_TAPS_DEF     : default taps per FIR band (sequencing window length)
//   QUEUE_DEPTH_DEF  : default circular sample queue depth
//   PTR_W_DEF        : default queue pointer width
//   wrap_sub()       : (ptr - n) mod depth via conditional add, for ptr < depth, n <= depth
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int unsigned NUM_TAPS_DEF    = 1021;
    localparam int unsigned QUEUE_DEPTH_DEF = 1536;
    localparam int unsigned PTR_W_DEF       = 11;

    // Depth is not a power of two, so a borrow is repaired by adding depth back.
    function automatic logic [31:0] wrap_sub(input logic [31:0] ptr,
                                             input logic [31:0] n,
                                             input logic [31:0] depth);
        logic [31:0] diff;
        diff = ptr - n;
        if (ptr < n) begin
            diff = diff + depth;
        end
        return diff;
    endfunction

endpackage

// File: rtl/fir_seq_ctrl_queue_ptr_wrap.sv
// queue_ptr_wrap: loadable circular-queue pointer, increments and wraps at QUEUE_DEPTH-1.
//   clk, rst  : clock, asynchronous active-high reset (ptr -> 0)
//   load      : load ptr with load_val (priority over inc)
//   load_val  : value to load
//   inc       : advance ptr by one, QUEUE_DEPTH-1 wraps to 0
//   ptr       : registered pointer
module queue_ptr_wrap #(
    parameter int unsigned QUEUE_DEPTH = 1536,
    parameter int unsigned PTR_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Pointer register with explicit wrap at the non power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            if (ptr == PTR_W'(QUEUE_DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequences one FIR band run per accepted sample, walking the queue read
// pointer over the NUM_TAPS newest samples (oldest first), then pulses out_vld.
// Optional feature macro: SEQ_CATCHUP_EN (one-deep pending start latch).
//   clk, rst    : clock, asynchronous active-high reset
//   smpl_vld    : 1-cycle pulse, new sample written to the queue
//   wr_ptr      : queue write pointer, valid with smpl_vld
//   primed      : queue holds at least NUM_TAPS samples
//   sequencing  : high for NUM_TAPS consecutive cycles per run
//   rd_ptr      : queue read address, one sample per sequencing cycle
//   out_vld     : 1-cycle pulse after the last tap
//   busy        : high whenever not IDLE
//   overrun     : sticky, a sample start was lost
module fir_seq_ctrl
    import fir_seq_pkg::*;
#(
    parameter int unsigned NUM_TAPS    = NUM_TAPS_DEF,
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int unsigned PTR_W       = PTR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smpl_vld,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic             primed,
    output logic             sequencing,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             out_vld,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [TAP_W-1:0] tap_cnt;
    logic [TAP_W-1:0] tap_cnt_nxt;
    logic             overrun_nxt;
    logic             ptr_load;
    logic             ptr_inc;
    logic [PTR_W-1:0] start_src;
    logic [PTR_W-1:0] ptr_load_val;

`ifdef SEQ_CATCHUP_EN
    logic             pend_vld;
    logic             pend_vld_nxt;
    logic [PTR_W-1:0] pend_ptr;
    logic [PTR_W-1:0] pend_ptr_nxt;
    logic             pend_take;
    logic             start_new;
`endif

    // Read pointer: loaded with the oldest tap address, then stepped once per tap.
    queue_ptr_wrap #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .PTR_W       (PTR_W)
    ) u_rd_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (ptr_load),
        .load_val (ptr_load_val),
        .inc      (ptr_inc),
        .ptr      (rd_ptr)
    );

    // Start address of a run is the NUM_TAPS-th sample behind the write pointer.
    assign ptr_load_val = PTR_W'(wrap_sub(32'(start_src), NUM_TAPS, QUEUE_DEPTH));

    // Next-state, tap counter, pointer control and overrun logic.
    always_comb begin
        state_nxt   = state;
        tap_cnt_nxt = tap_cnt;
        overrun_nxt = overrun;
        ptr_load    = 1'b0;
        ptr_inc     = 1'b0;
        start_src   = wr_ptr;
`ifdef SEQ_CATCHUP_EN
        pend_vld_nxt = pend_vld;
        pend_ptr_nxt = pend_ptr;
        pend_take    = 1'b0;
        start_new    = 1'b0;
`endif

        unique case (state)
            IDLE: state_nxt = IDLE;
            RUN: begin
                // rd_ptr holds on the last tap so it ends on the newest sample.
                if (tap_cnt == TAP_W'(NUM_TAPS - 1)) begin
                    state_nxt = DONE;
                end else begin
                    ptr_inc     = 1'b1;
                    tap_cnt_nxt = tap_cnt + TAP_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

`ifdef SEQ_CATCHUP_EN
        // A latched sample starts as soon as the previous run has completed.
        pend_take = pend_vld && (state != RUN);
        start_new = (state == IDLE) && !pend_vld && smpl_vld && primed;
        if (pend_take || start_new) begin
            state_nxt   = RUN;
            ptr_load    = 1'b1;
            tap_cnt_nxt = '0;
            start_src   = pend_take ? pend_ptr : wr_ptr;
        end
        if (pend_take) begin
            pend_vld_nxt = 1'b0;
        end
        // Samples arriving while busy go to the latch if it is (or is becoming) free.
        if (smpl_vld && !start_new && ((state != IDLE) || pend_take)) begin
            if (!pend_vld || pend_take) begin
                pend_vld_nxt = 1'b1;
                pend_ptr_nxt = wr_ptr;
            end else begin
                overrun_nxt = 1'b1;
            end
        end
`else
        if ((state == IDLE) && smpl_vld && primed) begin
            state_nxt   = RUN;
            ptr_load    = 1'b1;
            tap_cnt_nxt = '0;
        end
        if (smpl_vld && (state != IDLE)) begin
            overrun_nxt = 1'b1;
        end
`endif
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tap_cnt    <= '0;
            sequencing <= 1'b0;
            out_vld    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef SEQ_CATCHUP_EN
            pend_vld   <= 1'b0;
            pend_ptr   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            tap_cnt    <= tap_cnt_nxt;
            sequencing <= (state_nxt == RUN);
            out_vld    <= (state_nxt == DONE);
            busy       <= (state_nxt != IDLE);
            overrun    <= overrun_nxt;
`ifdef SEQ_CATCHUP_EN
            pend_vld   <= pend_vld_nxt;
            pend_ptr   <= pend_ptr_nxt;
`endif
        end
    end

endmodule
